// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller.
//   state_t        : controller FSM states (IDLE, RD, RESP)
//   region_t       : address decode result (RAM, OUT register, IN port, ERR)
//   OUT_ADDR_DEF   : default byte address of the output register
//   IN_ADDR_DEF    : default byte address of the input port
//   ERR_DATA       : load data returned for an undecoded address
//   decode_region(): maps a word-aligned byte address to a region
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RG_RAM = 2'd0,
        RG_OUT = 2'd1,
        RG_IN  = 2'd2,
        RG_ERR = 2'd3
    } region_t;

    localparam logic [31:0] OUT_ADDR_DEF = 32'hFFFF_0000;
    localparam logic [31:0] IN_ADDR_DEF  = 32'hFFFF_0004;
    localparam logic [31:0] ERR_DATA     = 32'hDEAD_BEEF;

    // aligned must already have bits [1:0] cleared. RAM occupies byte
    // addresses [0, 4*2^aw); nothing above it aliases back into the RAM.
    function automatic region_t decode_region(
        input logic [31:0] aligned,
        input int          aw,
        input logic [31:0] out_addr,
        input logic [31:0] in_addr
    );
        logic [31:0] ram_bytes;
        ram_bytes = 32'd4 << aw;
        if (aligned < ram_bytes)
            return RG_RAM;
        else if (aligned == out_addr)
            return RG_OUT;
        else if (aligned == in_addr)
            return RG_IN;
        else
            return RG_ERR;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Synchronous single-port RAM of 2^ADDR_WIDTH 32-bit words.
//   clk   : clock
//   we    : write enable, writes wdata to mem[addr] on the rising edge
//   addr  : word index
//   wdata : write data
//   rdata : registered read of mem[addr], valid one cycle after addr
// Contents are not reset.
module dmem_ram #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder for the core's load/store port.
// Serves one request at a time from a small RAM, a 16-bit output register
// (data_out) and a synchronised 16-bit input port (sw_in).
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake
//   req_we               : 1 = store, 0 = load
//   req_addr, req_wdata  : byte address (bits [1:0] ignored), store data
//   rsp_valid/rsp_ready  : response handshake
//   rsp_rdata, rsp_err   : load data (0 for stores), error flag
//   sw_in                : asynchronous external input
//   data_out             : memory-mapped output register
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. The source holds its payload stable while valid is high
// and ready is low; valid is never withdrawn before the transfer.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 4,
    parameter logic [31:0] OUT_ADDR   = OUT_ADDR_DEF,
    parameter logic [31:0] IN_ADDR    = IN_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [15:0] sw_in,
    output logic [15:0] data_out
);

    state_t  state;
    region_t ld_region;
    region_t req_region;

    logic [15:0]           sw_meta;
    logic [15:0]           sw_sync;
    logic [31:0]           req_aligned;
    logic                  accept;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_rdata;
    logic                  unused_addr_bits;

    // Byte offset within a word has no meaning here.
    assign unused_addr_bits = ^req_addr[1:0];

    assign req_aligned = {req_addr[31:2], 2'b00};
    assign req_region  = decode_region(req_aligned, ADDR_WIDTH, OUT_ADDR, IN_ADDR);

    assign req_ready = (state == ST_IDLE) & rst_n;
    assign accept    = req_valid & req_ready;

    // The RAM reads every cycle; only the read issued on the accept edge
    // of a load is consumed (in RD), so req_addr may change after accept.
    assign ram_we   = accept & req_we & (req_region == RG_RAM);
    assign ram_addr = req_addr[ADDR_WIDTH+1:2];

    dmem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    // Two-flop synchroniser for the asynchronous input port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ld_region <= RG_RAM;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            data_out  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_we) begin
                            if (req_region == RG_OUT)
                                data_out <= req_wdata[15:0];
                            // The input port is read-only, so a store to it
                            // is reported like an undecoded address.
                            rsp_err   <= (req_region == RG_IN) || (req_region == RG_ERR);
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            ld_region <= req_region;
                            state     <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    case (ld_region)
                        RG_RAM: begin
                            rsp_rdata <= ram_rdata;
                            rsp_err   <= 1'b0;
                        end
                        RG_OUT: begin
                            rsp_rdata <= {16'h0, data_out};
                            rsp_err   <= 1'b0;
                        end
                        RG_IN: begin
                            rsp_rdata <= {16'h0, sw_sync};
                            rsp_err   <= 1'b0;
                        end
                        default: begin
                            rsp_rdata <= ERR_DATA;
                            rsp_err   <= 1'b1;
                        end
                    endcase
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases plus randomized
// transactions against a behavioural memory model.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] sw_in;
    logic [15:0] data_out;

    dmem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .sw_in     (sw_in),
        .data_out  (data_out)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];          // {err, rdata} per expected response
    logic [31:0] model_mem [16];
    logic [15:0] model_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 0 = RAM, 1 = output register, 2 = input port, 3 = nothing
    function automatic int region_of(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w < 32'd64)            return 0;
        if (w == 32'hFFFF_0000)    return 1;
        if (w == 32'hFFFF_0004)    return 2;
        return 3;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_data_out",  data_out,  32'h0);
            chk("rst_rsp_valid", rsp_valid, 32'h0);
            chk("rst_req_ready", req_ready, 32'h0);
        end else begin
            chk("data_out", data_out, model_dout);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got rdata %h with no response expected", rsp_rdata);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e[31:0]);
                    chk("rsp_err",   rsp_err,   e[32]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Wait for acceptance; returns 0 on timeout.
    task automatic wait_accept(output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 20);
        ok = req_ready;
        if (!ok) chk("accept_timeout", 32'(n), 32'd0);
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall, output logic [31:0] got_rdata, output logic got_err);
        int          n;
        int          rg;
        bit          ok;
        logic [32:0] e;
        got_rdata = 'x;
        got_err   = 1'bx;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = (stall == 0);
        wait_accept(ok);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        rg = region_of(addr);
        if (we) begin
            e = {(rg >= 2), 32'h0};
        end else begin
            case (rg)
                0:       e = {1'b0, model_mem[addr[5:2]]};
                1:       e = {1'b0, 16'h0, model_dout};
                2:       e = {1'b0, 16'h0, sw_in};
                default: e = {1'b1, 32'hDEAD_BEEF};
            endcase
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (we && rg == 0) model_mem[addr[5:2]] = wdata;
        if (we && rg == 1) model_dout = wdata[15:0];
        // The controller must not depend on the request after acceptance.
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 10);
        chk("latency", 32'(n), we ? 32'd1 : 32'd2);
        if (!rsp_valid) begin
            void'(exp_q.pop_back());
            rsp_ready = 1'b0;
            return;
        end
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        if (stall > 0) begin
            for (int i = 1; i < stall; i++) begin
                @(negedge clk);
                chk("hold_valid", rsp_valid, 32'h1);
                chk("hold_rdata", rsp_rdata, got_rdata);
                chk("hold_err",   rsp_err,   got_err);
                chk("busy_ready", req_ready, 32'h0);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(negedge clk);
            chk("hold_rdata", rsp_rdata, got_rdata);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", rsp_valid, 32'h0);
        chk("post_ready", req_ready, 32'h1);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] r;
    logic        er;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        sw_in      = '0;
        model_dout = '0;

        // Reset, then idle.
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 32'h1);
        chk("valid_after_rst", rsp_valid, 32'h0);

        // Give every RAM word a known value.
        for (int i = 0; i < 16; i++)
            do_req(1'b1, 32'(i * 4), $urandom, 0, r, er);

        // RAM store then loads.
        do_req(1'b1, 32'h8, 32'h1234_5678, 0, r, er);
        chk("st_rdata_lit", r, 32'h0);
        chk("st_err_lit", er, 32'h0);
        do_req(1'b0, 32'h8, 32'h0, 0, r, er);
        chk("ld8_lit", r, 32'h1234_5678);
        do_req(1'b0, 32'hA, 32'h0, 0, r, er);
        chk("ldA_lit", r, 32'h1234_5678);

        // Output register.
        do_req(1'b1, 32'hFFFF_0000, 32'hABCD_00FF, 0, r, er);
        chk("dout_lit", data_out, 32'h00FF);
        do_req(1'b0, 32'hFFFF_0000, 32'h0, 0, r, er);
        chk("ld_out_lit", r, 32'h0000_00FF);

        // Input port.
        @(posedge clk); #1;
        sw_in = 16'hA5A5;
        repeat (4) @(posedge clk);
        do_req(1'b0, 32'hFFFF_0004, 32'h0, 0, r, er);
        chk("ld_in_lit", r, 32'h0000_A5A5);
        do_req(1'b1, 32'hFFFF_0004, 32'h0000_1234, 0, r, er);
        chk("st_in_err_lit", er, 32'h1);
        chk("st_in_dout_lit", data_out, 32'h00FF);

        // Undecoded load under backpressure.
        do_req(1'b0, 32'h0000_1000, 32'h0, 5, r, er);
        chk("err_rdata_lit", r, 32'hDEAD_BEEF);
        chk("err_flag_lit", er, 32'h1);

        // Reset in the middle of a load.
        do_req(1'b1, 32'h4, 32'hCAFE_F00D, 0, r, er);
        begin
            bit ok;
            @(posedge clk); #1;
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = 32'h4;
            rsp_ready = 1'b1;
            wait_accept(ok);
            @(posedge clk); #1;
            req_valid  = 1'b0;
            rst_n      = 1'b0;
            model_dout = '0;
            repeat (2) @(negedge clk);
            @(posedge clk); #1;
            rst_n = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("no_rsp_after_rst", rsp_valid, 32'h0);
            end
            rsp_ready = 1'b0;
        end
        do_req(1'b0, 32'h4, 32'h0, 0, r, er);
        chk("ld4_after_rst_lit", r, 32'hCAFE_F00D);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            @(posedge clk); #1;
            sw_in = 16'($urandom);
            repeat (3) @(posedge clk);
            case ($urandom_range(0, 5))
                0, 1, 2: a = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
                3:       a = 32'hFFFF_0000 | 32'($urandom_range(0, 3));
                4:       a = 32'hFFFF_0004 | 32'($urandom_range(0, 3));
                default: begin
                    a = $urandom;
                    if (region_of(a) != 3) a = 32'h0000_0100;
                end
            endcase
            do_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), r, er);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory responder for the core's load/store port: the read-capable counterpart of the existing write-only memory controller.
- Accepts one request at a time (load or store) over a valid/ready handshake and returns a response over a valid/ready handshake.
- Backs a small word-addressed synchronous RAM, a memory-mapped 16-bit output register (data_out) and a memory-mapped 16-bit input port (sw_in).
- Sits between core and top-level I/O; replaces the write-only path in the top level.

Parameters:
ADDR_WIDTH, 4, log2 of RAM depth in 32-bit words (depth 16)
OUT_ADDR, 32'hFFFF_0000, byte address of output register
IN_ADDR, 32'hFFFF_0004, byte address of input port

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address; bits [1:0] ignored
req_wdata  input  32  store data
rsp_valid  output  1  response present
rsp_ready  input  1  core accepts response
rsp_rdata  output  32  load data; 0 for stores
rsp_err  output  1  address decoded to nothing, or store to IN_ADDR
sw_in  input  16  asynchronous external input
data_out  output  16  output register

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, data_out=0, synchronizer flops=0. RAM contents are not reset.
- req_ready = (state==IDLE) & rst_n, combinational; no combinational path from req_valid.
- Decode, on aligned address A = {req_addr[31:2],2'b00}:
  - RAM if A < 4*2^ADDR_WIDTH; word index = req_addr[ADDR_WIDTH+1:2].
  - OUT if A==OUT_ADDR; IN if A==IN_ADDR; otherwise ERR.
- FSM states: IDLE, RD, RESP.
- IDLE, accept = req_valid & req_ready:
  - Store: in the accept edge, RAM write (RAM) or data_out <= req_wdata[15:0] (OUT). IN or ERR writes nothing and sets err. Next state RESP with rsp_rdata=0. Store latency: rsp_valid 1 cycle after accept.
  - Load: latch decode/err, issue RAM read, next state RD.
- RD: next state RESP with rsp_rdata =
  - RAM word (1-cycle synchronous read), or
  - {16'h0,data_out} for OUT, or
  - {16'h0,sw_sync} for IN, or
  - 32'hDEAD_BEEF with rsp_err=1 for ERR.
  - Load latency: rsp_valid 2 cycles after accept.
- RESP: rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_valid & rsp_ready, then IDLE (rsp_valid=0 next cycle). A new request is accepted no earlier than the cycle after the response handshake; max throughput is one store per 2 cycles, one load per 3 cycles.
- sw_in passes through a 2-flop synchronizer (sw_sync). A load of IN returns the value sampled at the RD edge.
- Load of OUT in the cycle after a store to OUT returns the new value.
- RAM write and read never occur in the same cycle (single outstanding request), so no read-during-write hazard.
- req_addr[1:0] != 0: ignored, not an error.
- Address wrap: no aliasing; any address above the RAM range that is not OUT or IN is ERR.
- Reset mid-operation: the outstanding request is dropped and no response is issued; data_out clears to 0.
- The core must hold req_* stable while req_valid & !req_ready (the controller does not check this).

Decomposition:
- Shared package dmem_pkg: state encoding (IDLE/RD/RESP), region enum (RAM/OUT/IN/ERR), OUT_ADDR/IN_ADDR defaults, ERR_DATA=32'hDEAD_BEEF.
- One natural sub-module: dmem_ram. Synchronous single-port RAM with parameter ADDR_WIDTH and ports clk, we, addr, wdata, rdata; no reset. Registered read, 1-cycle latency.
- Synchronizer and FSM stay in dmem_ctrl.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> data_out=0, rsp_valid=0, req_ready=0 during reset and 1 in the first cycle after release.
- Store then load RAM: store 32'h1234_5678 to 0x8, rsp_ready=1 -> rsp_valid 1 cycle after accept, rdata=0, err=0. Then load 0x8 -> rsp_valid 2 cycles after accept, rdata=32'h1234_5678. Load 0xA -> same word.
- Output register: store 32'hABCD_00FF to 0xFFFF_0000 -> data_out=16'h00FF on the next cycle. Load 0xFFFF_0000 -> rdata=32'h0000_00FF.
- Input port: sw_in=16'hA5A5 held 4 cycles, load 0xFFFF_0004 -> rdata=32'h0000_A5A5. Store to 0xFFFF_0004 -> err=1, data_out unchanged.
- Error and backpressure: load 0x0000_1000 with rsp_ready=0 for 5 cycles -> rsp_valid=1, rdata=32'hDEAD_BEEF, err=1 stable for all 5 cycles, req_ready=0. Raise rsp_ready -> back to IDLE next cycle.
- Reset mid-load: accept a load of 0x4, pull rst_n low in RD -> no rsp_valid after release. RAM word 0x4 retains its prior value on a subsequent load.
